// File: rtl/cci_mpf_csr_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cci_mpf_csr_mmio_ctrl
// Purpose : MMIO-side CSR manager for MPF shims. Decodes host MMIO writes into
//           the VC map, latency QoS and WRO control registers (each with a
//           one-cycle valid strobe), counts shim events, and answers MMIO reads
//           in request order through a read-request FIFO (MMIO has no flow
//           control, so requests are queued until a response slot is free).
// Ports   : clk, reset_n (async, active low)
//           i_mmio_wr_*  : MMIO write request (DW address, 64-bit data)
//           i_mmio_rd_*  : MMIO read request (DW address, 9-bit tid)
//           i_rsp_ready  : response slot available; o_rsp_* : read response
//           o_*_ctrl / o_*_ctrl_valid : shim configuration + update strobe
//           i_vc_map_history : read-only history readback
//           i_ev_*       : event pulses feeding saturating counters
// Revision: 1.0 - initial release
// ============================================================================
module cci_mpf_csr_mmio_ctrl #(
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter int          RD_FIFO_DEPTH = 4,
  parameter int          CNT_WIDTH     = 48,
  parameter logic [63:0] VC_MAP_RST    = 64'h0,
  parameter logic [63:0] LAT_QOS_RST   = 64'h0,
  parameter logic [63:0] WRO_RST       = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_mmio_wr_valid,
  input  logic [15:0] i_mmio_wr_addr,
  input  logic [63:0] i_mmio_wr_data,
  input  logic        i_mmio_rd_valid,
  input  logic [15:0] i_mmio_rd_addr,
  input  logic [8:0]  i_mmio_rd_tid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_valid,
  output logic [63:0] o_rsp_data,
  output logic [8:0]  o_rsp_tid,
  output logic [63:0] o_vc_map_ctrl,
  output logic        o_vc_map_ctrl_valid,
  input  logic [63:0] i_vc_map_history,
  output logic [63:0] o_latency_qos_ctrl,
  output logic        o_latency_qos_ctrl_valid,
  output logic [63:0] o_wro_ctrl,
  output logic        o_wro_ctrl_valid,
  input  logic        i_ev_vc_map_changed,
  input  logic        i_ev_wro_conflict,
  input  logic        i_ev_pwrite
);

  localparam int c_PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int c_ENT_W = 13;  // {idx[2:0], odd, tid[8:0]}
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  // ---------------------------------------------------------------- decode
  logic       w_wr_hit, w_rd_hit;
  logic [2:0] w_wr_idx, w_rd_idx;
  logic       w_rd_odd;
  logic       w_wr_vc, w_wr_lat, w_wr_wro, w_clr_cnt, w_clr_ovf;

  // Odd DW writes are dropped here; odd reads still queue and return zero.
  assign w_wr_hit  = i_mmio_wr_valid && (i_mmio_wr_addr[15:4] == BASE_ADDR[15:4])
                     && !i_mmio_wr_addr[0];
  assign w_wr_idx  = i_mmio_wr_addr[3:1];
  assign w_rd_hit  = i_mmio_rd_valid && (i_mmio_rd_addr[15:4] == BASE_ADDR[15:4]);
  assign w_rd_idx  = i_mmio_rd_addr[3:1];
  assign w_rd_odd  = i_mmio_rd_addr[0];

  assign w_wr_vc   = w_wr_hit && (w_wr_idx == 3'd0);
  assign w_wr_lat  = w_wr_hit && (w_wr_idx == 3'd2);
  assign w_wr_wro  = w_wr_hit && (w_wr_idx == 3'd3);
  assign w_clr_cnt = w_wr_hit && (w_wr_idx == 3'd7) && i_mmio_wr_data[0];
  assign w_clr_ovf = w_wr_hit && (w_wr_idx == 3'd7) && i_mmio_wr_data[1];

  // ------------------------------------------------------ control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_vc_map_ctrl            <= VC_MAP_RST;
      o_latency_qos_ctrl       <= LAT_QOS_RST;
      o_wro_ctrl               <= WRO_RST;
      o_vc_map_ctrl_valid      <= 1'b0;
      o_latency_qos_ctrl_valid <= 1'b0;
      o_wro_ctrl_valid         <= 1'b0;
    end else begin
      o_vc_map_ctrl_valid      <= w_wr_vc;
      o_latency_qos_ctrl_valid <= w_wr_lat;
      o_wro_ctrl_valid         <= w_wr_wro;
      if (w_wr_vc)  o_vc_map_ctrl      <= i_mmio_wr_data;
      if (w_wr_lat) o_latency_qos_ctrl <= i_mmio_wr_data;
      if (w_wr_wro) o_wro_ctrl         <= i_mmio_wr_data;
    end
  end

  // ------------------------------------------------------- event counters
  // [0] vc_map_changed, [1] wro_conflict, [2] pwrite
  logic [2:0][CNT_WIDTH-1:0] r_cnt;
  logic [2:0]                w_ev;
  assign w_ev = {i_ev_pwrite, i_ev_wro_conflict, i_ev_vc_map_changed};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_clr_cnt)                          r_cnt[k] <= '0;  // clear beats event
        else if (w_ev[k] && r_cnt[k] != c_CNT_MAX) r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ read-request FIFO
  logic [c_ENT_W-1:0] r_fifo [RD_FIFO_DEPTH];
  logic [c_PTR_W:0]   r_wr_ptr, r_rd_ptr;
  logic               w_empty, w_full, w_pop, w_push;
  logic               r_ovf;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_pop   = !w_empty && i_rsp_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = w_rd_hit && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= {w_rd_idx, w_rd_odd, i_mmio_rd_tid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_hit && !w_push) r_ovf <= 1'b1;  // dropped request is never lost silently
      else if (w_clr_ovf)      r_ovf <= 1'b0;
    end
  end

  // ------------------------------------------------- response data select
  logic [c_ENT_W-1:0] w_head;
  logic [63:0]        w_rd_data;
  assign w_head = r_fifo[r_rd_ptr[c_PTR_W-1:0]];

  // Registers are sampled at pop time, so writes that land while the read
  // is queued are visible to it.
  always_comb begin
    w_rd_data = 64'h0;
    if (!w_head[9]) begin
      case (w_head[12:10])
        3'd0:    w_rd_data = o_vc_map_ctrl;
        3'd1:    w_rd_data = i_vc_map_history;
        3'd2:    w_rd_data = o_latency_qos_ctrl;
        3'd3:    w_rd_data = o_wro_ctrl;
        3'd4:    w_rd_data = 64'(r_cnt[0]);
        3'd5:    w_rd_data = 64'(r_cnt[1]);
        3'd6:    w_rd_data = 64'(r_cnt[2]);
        default: w_rd_data = {63'h0, r_ovf};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= 64'h0;
      o_rsp_tid   <= 9'h0;
    end else begin
      o_rsp_valid <= w_pop;
      if (w_pop) begin
        o_rsp_data <= w_rd_data;
        o_rsp_tid  <= w_head[8:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_csr_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cci_mpf_csr_mmio_ctrl
// Purpose : Directed self-checking bench for cci_mpf_csr_mmio_ctrl. Inputs are
//           driven and outputs sampled on the falling clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cci_mpf_csr_mmio_ctrl;

  localparam logic [15:0] BASE = 16'h0120;
  localparam logic [63:0] VRST = 64'h1111, LRST = 64'h2222, WRST = 64'h3333;
  localparam logic [63:0] HIST = 64'hDEAD_0000_F00D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid, rd_valid, rsp_ready;
  logic [15:0] wr_addr, rd_addr;
  logic [63:0] wr_data;
  logic [8:0]  rd_tid;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [8:0]  rsp_tid;
  logic [63:0] vc_ctrl, lat_ctrl, wro_ctrl;
  logic        vc_v, lat_v, wro_v;
  logic        ev_vc, ev_wro, ev_pw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cci_mpf_csr_mmio_ctrl #(
    .BASE_ADDR(BASE), .RD_FIFO_DEPTH(4), .CNT_WIDTH(4),
    .VC_MAP_RST(VRST), .LAT_QOS_RST(LRST), .WRO_RST(WRST)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_mmio_wr_valid(wr_valid), .i_mmio_wr_addr(wr_addr), .i_mmio_wr_data(wr_data),
    .i_mmio_rd_valid(rd_valid), .i_mmio_rd_addr(rd_addr), .i_mmio_rd_tid(rd_tid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_tid(rsp_tid),
    .o_vc_map_ctrl(vc_ctrl), .o_vc_map_ctrl_valid(vc_v),
    .i_vc_map_history(HIST),
    .o_latency_qos_ctrl(lat_ctrl), .o_latency_qos_ctrl_valid(lat_v),
    .o_wro_ctrl(wro_ctrl), .o_wro_ctrl_valid(wro_v),
    .i_ev_vc_map_changed(ev_vc), .i_ev_wro_conflict(ev_wro), .i_ev_pwrite(ev_pw)
  );

  // Called at a falling edge; returns one falling edge later with the write applied.
  task automatic drive_wr(input logic [15:0] a, input logic [63:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Issue one read (rsp_ready assumed high) and wait a bounded time for its response.
  task automatic rd_get(input logic [15:0] a, input logic [8:0] t,
                        output logic [63:0] d, output logic [8:0] rt, output bit got);
    rd_valid = 1'b1; rd_addr = a; rd_tid = t;
    @(negedge clk);
    rd_valid = 1'b0;
    got = 1'b0; d = '0; rt = '0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) begin
        got = 1'b1; d = rsp_data; rt = rsp_tid;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vc_ctrl !== VRST) begin errors++; $display("FAIL rst_vc: got %h exp %h", vc_ctrl, VRST); end
    checks++; if (lat_ctrl !== LRST) begin errors++; $display("FAIL rst_lat: got %h exp %h", lat_ctrl, LRST); end
    checks++; if (wro_ctrl !== WRST) begin errors++; $display("FAIL rst_wro: got %h exp %h", wro_ctrl, WRST); end
    checks++; if ({vc_v, lat_v, wro_v, rsp_valid} !== 4'b0) begin errors++; $display("FAIL rst_valids: got %b exp 0000", {vc_v, lat_v, wro_v, rsp_valid}); end
    checks++; if ({rsp_data, rsp_tid} !== 73'h0) begin errors++; $display("FAIL rst_rsp: got %h/%h exp 0/0", rsp_data, rsp_tid); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    drive_wr(BASE + 16'd0, 64'hA5);
    checks++; if (vc_ctrl !== 64'hA5) begin errors++; $display("FAIL wr_vc_val: got %h exp %h", vc_ctrl, 64'hA5); end
    checks++; if ({vc_v, lat_v, wro_v} !== 3'b100) begin errors++; $display("FAIL wr_vc_strobe: got %b exp 100", {vc_v, lat_v, wro_v}); end
    @(negedge clk);
    checks++; if (vc_v !== 1'b0) begin errors++; $display("FAIL wr_vc_strobe_len: got %b exp 0", vc_v); end
    drive_wr(BASE + 16'd4, 64'hBEEF);
    checks++; if (lat_ctrl !== 64'hBEEF || {vc_v, lat_v, wro_v} !== 3'b010) begin errors++; $display("FAIL wr_lat: got %h/%b exp beef/010", lat_ctrl, {vc_v, lat_v, wro_v}); end
    drive_wr(BASE + 16'd6, 64'hCAFE);
    checks++; if (wro_ctrl !== 64'hCAFE || {vc_v, lat_v, wro_v} !== 3'b001) begin errors++; $display("FAIL wr_wro: got %h/%b exp cafe/001", wro_ctrl, {vc_v, lat_v, wro_v}); end
    @(negedge clk);
  endtask

  task automatic test_read_latency;
    drive_wr(BASE + 16'd4, 64'h1234);
    rd_valid = 1'b1; rd_addr = BASE + 16'd4; rd_tid = 9'h1F;
    @(negedge clk);
    rd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b exp 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h1234 || rsp_tid !== 9'h1F) begin errors++; $display("FAIL lat_rsp: got v=%b %h tid %h exp v=1 1234 tid 1f", rsp_valid, rsp_data, rsp_tid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_map;
    logic [63:0] d; logic [8:0] t; bit g;
    rd_get(BASE + 16'd0, 9'h002, d, t, g);
    checks++; if (!g || d !== 64'hA5 || t !== 9'h002) begin errors++; $display("FAIL map_vc: got g=%b %h tid %h exp a5 tid 002", g, d, t); end
    rd_get(BASE + 16'd2, 9'h003, d, t, g);
    checks++; if (!g || d !== HIST) begin errors++; $display("FAIL map_hist: got g=%b %h exp %h", g, d, HIST); end
    rd_get(BASE + 16'd6, 9'h004, d, t, g);
    checks++; if (!g || d !== 64'hCAFE) begin errors++; $display("FAIL map_wro: got g=%b %h exp cafe", g, d); end
  endtask

  task automatic test_illegal;
    logic [63:0] d; logic [8:0] t; bit g;
    int seen;
    wr_valid = 1'b1; wr_addr = BASE + 16'd16; wr_data = 64'h77;
    rd_valid = 1'b1; rd_addr = BASE + 16'd16; rd_tid = 9'h055;
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid || vc_v || lat_v || wro_v) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0 || vc_ctrl !== 64'hA5) begin errors++; $display("FAIL oor_ignored: got activity=%0d vc=%h exp 0/a5", seen, vc_ctrl); end
    rd_get(BASE + 16'd1, 9'h056, d, t, g);
    checks++; if (!g || d !== 64'h0 || t !== 9'h056) begin errors++; $display("FAIL odd_read: got g=%b %h tid %h exp 0 tid 056", g, d, t); end
    drive_wr(BASE + 16'd1, 64'h99);
    checks++; if (vc_v !== 1'b0 || vc_ctrl !== 64'hA5) begin errors++; $display("FAIL odd_write: got %b/%h exp 0/a5", vc_v, vc_ctrl); end
    drive_wr(BASE + 16'd2, 64'h99);
    checks++; if ({vc_v, lat_v, wro_v} !== 3'b000) begin errors++; $display("FAIL ro_write: got %b exp 000", {vc_v, lat_v, wro_v}); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d; logic [8:0] t; bit g;
    logic [8:0] tids [8];
    int n;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rd_valid = 1'b1; rd_addr = BASE; rd_tid = 9'(i);
      @(negedge clk);
    end
    rd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold: got %b exp 0", rsp_valid); end
    rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (n < 8) tids[n] = rsp_tid;
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (tids[i] !== 9'(i + 1)) begin errors++; $display("FAIL b2b_order%0d: got %h exp %h", i, tids[i], 9'(i + 1)); end
    end
    rd_get(BASE + 16'd14, 9'h010, d, t, g);
    checks++; if (!g || d !== 64'h1) begin errors++; $display("FAIL ovf_set: got g=%b %h exp 1", g, d); end
    drive_wr(BASE + 16'd14, 64'h2);
    rd_get(BASE + 16'd14, 9'h011, d, t, g);
    checks++; if (!g || d !== 64'h0) begin errors++; $display("FAIL ovf_clear: got g=%b %h exp 0", g, d); end
  endtask

  task automatic test_full_push_pop;
    logic [63:0] d; logic [8:0] t; bit g;
    int n;
    rsp_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      rd_valid = 1'b1; rd_addr = BASE; rd_tid = 9'(i);
      @(negedge clk);
    end
    rd_tid = 9'd15; rsp_ready = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) begin
        checks++; if (rsp_tid !== 9'(11 + n)) begin errors++; $display("FAIL fpp_order%0d: got %h exp %h", n, rsp_tid, 9'(11 + n)); end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != 5) begin errors++; $display("FAIL fpp_count: got %0d exp 5", n); end
    rd_get(BASE + 16'd14, 9'h012, d, t, g);
    checks++; if (!g || d !== 64'h0) begin errors++; $display("FAIL fpp_no_ovf: got g=%b %h exp 0", g, d); end
  endtask

  task automatic test_counters;
    logic [63:0] d; logic [8:0] t; bit g;
    for (int i = 0; i < 10; i++) begin
      ev_pw = 1'b1; @(negedge clk);
      ev_pw = 1'b0; @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      ev_vc = 1'b1; @(negedge clk);
    end
    ev_vc = 1'b0;
    rd_get(BASE + 16'd12, 9'h020, d, t, g);
    checks++; if (!g || d !== 64'd10) begin errors++; $display("FAIL cnt_pwrite: got g=%b %0d exp 10", g, d); end
    rd_get(BASE + 16'd8, 9'h021, d, t, g);
    checks++; if (!g || d !== 64'd3) begin errors++; $display("FAIL cnt_vc: got g=%b %0d exp 3", g, d); end
    ev_pw = 1'b1;
    drive_wr(BASE + 16'd14, 64'h1);
    ev_pw = 1'b0;
    rd_get(BASE + 16'd12, 9'h022, d, t, g);
    checks++; if (!g || d !== 64'd0) begin errors++; $display("FAIL cnt_clear: got g=%b %0d exp 0", g, d); end
    ev_wro = 1'b1;
    repeat (20) @(negedge clk);
    ev_wro = 1'b0;
    rd_get(BASE + 16'd10, 9'h023, d, t, g);
    checks++; if (!g || d !== 64'd15) begin errors++; $display("FAIL cnt_sat: got g=%b %0d exp 15", g, d); end
  endtask

  task automatic test_wr_rd_same_cycle;
    int n;
    logic [63:0] d;
    wr_valid = 1'b1; wr_addr = BASE + 16'd6; wr_data = 64'h5A5A;
    rd_valid = 1'b1; rd_addr = BASE + 16'd6; rd_tid = 9'h042;
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    checks++; if (wro_v !== 1'b1 || wro_ctrl !== 64'h5A5A) begin errors++; $display("FAIL sim_wr: got %b/%h exp 1/5a5a", wro_v, wro_ctrl); end
    n = 0; d = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) begin n++; d = rsp_data; end
    end
    checks++; if (n != 1 || d !== 64'h5A5A) begin errors++; $display("FAIL sim_rd: got n=%0d %h exp 1 5a5a", n, d); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] d; logic [8:0] t; bit g;
    int seen;
    rsp_ready = 1'b0;
    drive_wr(BASE, 64'h4444);
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_addr = BASE; rd_tid = 9'(30 + i);
      @(negedge clk);
    end
    rd_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || vc_ctrl !== VRST || wro_ctrl !== WRST || lat_ctrl !== LRST) begin errors++; $display("FAIL rstmid_regs: got %b %h %h %h exp 0 %h %h %h", rsp_valid, vc_ctrl, lat_ctrl, wro_ctrl, VRST, LRST, WRST); end
    @(negedge clk);
    reset_n = 1'b1; rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_flush: got %0d responses exp 0", seen); end
    rd_get(BASE, 9'h077, d, t, g);
    checks++; if (!g || d !== VRST || t !== 9'h077) begin errors++; $display("FAIL rstmid_read: got g=%b %h tid %h exp %h tid 077", g, d, t, VRST); end
  endtask

  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0; rd_tid = '0;
    ev_vc = 1'b0; ev_wro = 1'b0; ev_pw = 1'b0;
    @(negedge clk);
    test_reset;
    test_write;
    test_read_latency;
    test_map;
    test_illegal;
    test_back_to_back;
    test_full_push_pop;
    test_counters;
    test_wr_rd_same_cycle;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
